// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction fetch unit with AXI4-Lite read prefetch, instruction queue and redirect
module ifu_prefetch #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   // instruction memory AR channel
   output logic [XLEN-1:0] araddr,
   output logic            arvalid,
   input  logic            arready,
   // instruction memory R channel
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      rresp,
   input  logic            rvalid,
   output logic            rready,
   // control-flow change from the back end
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   // decode-side queue head
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_fault,
   input  logic            inst_ready
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0]     LIMIT  = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0]   C_ONE  = CW'(1);
   localparam logic [PW-1:0]   P_ONE  = PW'(1);
   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

   // AR channel and fetch PC state
   logic            r_arvalid;
   logic [XLEN-1:0] r_araddr;
   logic [XLEN-1:0] r_fetch_pc;

   // response tracking state
   logic [XLEN-1:0] r_resp_pc;
   logic            r_halted;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_discard;

   // instruction queue storage and pointers
   logic [XLEN-1:0] r_q_data  [DEPTH];
   logic [XLEN-1:0] r_q_pc    [DEPTH];
   logic            r_q_fault [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;

   // combinational control
   logic            w_ar_hs;
   logic            w_r_hs;
   logic            w_discard_hit;
   logic            w_push;
   logic            w_fault;
   logic            w_pop;
   logic [CW:0]     w_inflight;
   logic            w_ar_free;
   logic            w_launch;
   logic [CW-1:0]   w_out_next;
   logic            w_pend_next;
   logic [XLEN-1:0] w_redir_pc;
   logic            w_unused_redirect_lsb;

   assign rready     = 1'b1;
   assign arvalid    = r_arvalid;
   assign araddr     = r_araddr;

   assign w_ar_hs    = r_arvalid & arready;
   assign w_r_hs     = rvalid & rready;

   // a response is stale while older requests are still owed to a flushed stream
   assign w_discard_hit = w_r_hs & (r_discard != '0);
   assign w_push        = w_r_hs & ~w_discard_hit & ~redirect;
   assign w_fault       = w_push & (rresp != 2'b00);
   assign w_pop         = (r_count != '0) & inst_ready & ~redirect;

   // every queued, outstanding or pending request holds one queue slot in reserve
   assign w_inflight = {1'b0, r_count} + {1'b0, r_outstanding} + (CW + 1)'(r_arvalid);
   assign w_ar_free  = ~r_arvalid | arready;

   // a fault arriving this cycle already stops the next launch
   assign w_launch = w_ar_free & ~r_halted & ~w_fault & ~redirect & (w_inflight < LIMIT);

   assign w_out_next  = r_outstanding + CW'(w_ar_hs) - CW'(w_r_hs);
   assign w_pend_next = r_arvalid & ~w_ar_hs;

   assign w_redir_pc            = {redirect_pc[XLEN-1:2], 2'b00};
   assign w_unused_redirect_lsb = ^redirect_pc[1:0];

   assign inst_valid = (r_count != '0);
   assign inst       = r_q_data[r_rd_ptr];
   assign inst_pc    = r_q_pc[r_rd_ptr];
   assign inst_fault = r_q_fault[r_rd_ptr];

   // AR register: launch a new request or hold the pending one until accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_arvalid <= 1'b0;
         r_araddr  <= RESET_PC;
      end else if (w_launch) begin
         r_arvalid <= 1'b1;
         r_araddr  <= r_fetch_pc;
      end else if (w_ar_hs) begin
         r_arvalid <= 1'b0;
      end
   end

   // fetch PC: next address to request, restarted by a redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
      end else if (redirect) begin
         r_fetch_pc <= w_redir_pc;
      end else if (w_launch) begin
         r_fetch_pc <= r_fetch_pc + PC_INC;
      end
   end

   // response PC and halt: tag accepted words and stop fetching after an access fault
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_resp_pc <= RESET_PC;
         r_halted  <= 1'b0;
      end else if (redirect) begin
         r_resp_pc <= w_redir_pc;
         r_halted  <= 1'b0;
      end else begin
         if (w_push) begin
            r_resp_pc <= r_resp_pc + PC_INC;
         end
         if (w_fault) begin
            r_halted <= 1'b1;
         end
      end
   end

   // outstanding count: accepted ARs whose R beat has not yet arrived
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
      end else begin
         r_outstanding <= w_out_next;
      end
   end

   // discard count: on redirect every request still owed (outstanding or pending) becomes stale
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_discard <= '0;
      end else if (redirect) begin
         r_discard <= w_out_next + CW'(w_pend_next);
      end else if (w_discard_hit) begin
         r_discard <= r_discard - C_ONE;
      end
   end

   // queue storage: write accepted responses at the tail
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_q_data[i]  <= '0;
            r_q_pc[i]    <= '0;
            r_q_fault[i] <= 1'b0;
         end
      end else if (w_push) begin
         r_q_data[r_wr_ptr]  <= rdata;
         r_q_pc[r_wr_ptr]    <= r_resp_pc;
         r_q_fault[r_wr_ptr] <= (rresp != 2'b00);
      end
   end

   // queue pointers and occupancy, emptied by a redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + P_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + P_ONE;
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - randomized and directed self-checking bench for ifu_prefetch
module tb_ifu_prefetch;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        inst_ready = 1'b0;

   ifu_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
      .inst_fault(inst_fault), .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int epoch; int ready; } mreq_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; logic fault; } ent_t;

   mreq_t       mem_q[$];
   ent_t        exp_q[$];
   ent_t        pop_log[$];
   logic [31:0] launch_log[$];

   int checks = 0, failures = 0;
   int cyc = 0, epoch = 0, ar_epoch = 0, ar_hs_count = 0, pops_total = 0;
   logic [31:0] m_fetch, m_resp, p_araddr, force_pc;
   logic [31:0] fault_addr = 32'h1;
   bit halted, p_arvalid, p_arready, exp_launch, ev_pop, ev_rhs;
   bit rst_req = 1'b1, force_redir = 1'b0, rand_fault_en = 1'b0;
   int ar_pct = 100, r_pct = 100, ir_pct = 100, redir_pct = 0, lat_min = 0, lat_max = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] memdata(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit faulty(input logic [31:0] a);
      return (a == fault_addr) || (rand_fault_en && (a[6:2] == 5'h13));
   endfunction

   task automatic model_init();
      mem_q.delete(); exp_q.delete(); pop_log.delete(); launch_log.delete();
      epoch = 0; ar_epoch = 0; ar_hs_count = 0;
      m_fetch = RESET_PC; m_resp = RESET_PC; halted = 0;
      p_arvalid = 0; p_arready = 0; p_araddr = '0; exp_launch = 0;
   endtask

   // outputs after the last edge against the model
   task automatic compare();
      bit launched;
      if (rst) begin
         chk(arvalid == 1'b0, "rst_arvalid", arvalid, 0);
         chk(araddr == RESET_PC, "rst_araddr", araddr, RESET_PC);
         chk(rready == 1'b1, "rst_rready", rready, 1);
         chk(inst_valid == 1'b0, "rst_inst_valid", inst_valid, 0);
         chk(inst == 32'h0, "rst_inst", inst, 0);
         chk(inst_pc == 32'h0, "rst_inst_pc", inst_pc, 0);
         chk(inst_fault == 1'b0, "rst_inst_fault", inst_fault, 0);
         return;
      end
      launched = arvalid && (!p_arvalid || p_arready);
      chk(launched == exp_launch, "launch", launched, exp_launch);
      if (p_arvalid && !p_arready)
         chk(arvalid && (araddr == p_araddr), "ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (launched) begin
         chk(araddr == m_fetch, "araddr", araddr, m_fetch);
         launch_log.push_back(araddr);
         m_fetch  = m_fetch + 32'd4;
         ar_epoch = epoch;
      end
      chk(rready == 1'b1, "rready", rready, 1);
      chk(inst_valid == (exp_q.size() != 0), "inst_valid", inst_valid, exp_q.size() != 0);
      if (inst_valid && exp_q.size() != 0) begin
         chk(inst_pc == exp_q[0].pc, "inst_pc", inst_pc, exp_q[0].pc);
         chk(inst == exp_q[0].data, "inst", inst, exp_q[0].data);
         chk(inst_fault == exp_q[0].fault, "inst_fault", inst_fault, exp_q[0].fault);
      end
      chk(exp_q.size() + mem_q.size() + int'(arvalid) <= DEPTH, "credit",
          exp_q.size() + mem_q.size() + int'(arvalid), DEPTH);
   endtask

   task automatic drive();
      arready    = ($urandom_range(0, 99) < ar_pct);
      inst_ready = ($urandom_range(0, 99) < ir_pct);
      if (force_redir) begin
         redirect = 1'b1; redirect_pc = force_pc; force_redir = 1'b0;
      end else if ($urandom_range(0, 99) < redir_pct) begin
         redirect = 1'b1; redirect_pc = $urandom_range(0, 1023);
      end else begin
         redirect = 1'b0; redirect_pc = $urandom;
      end
      if (mem_q.size() != 0 && cyc >= mem_q[0].ready && $urandom_range(0, 99) < r_pct) begin
         rvalid = 1'b1;
         rdata  = memdata(mem_q[0].addr);
         rresp  = faulty(mem_q[0].addr) ? 2'($urandom_range(1, 3)) : 2'b00;
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
         rresp  = 2'($urandom_range(0, 3));
      end
   endtask

   // model update for the coming edge, from stable pre-edge signals
   task automatic eval();
      bit ar_hs, r_hs, pop, redir, free;
      int credit;
      mreq_t e;
      ar_hs  = arvalid && arready;
      r_hs   = rvalid && rready;
      pop    = inst_valid && inst_ready;
      redir  = redirect;
      free   = !arvalid || arready;
      credit = exp_q.size() + mem_q.size() + int'(arvalid);
      ev_pop = pop; ev_rhs = r_hs;
      if (pop && !redir) begin
         pop_log.push_back('{inst, inst_pc, inst_fault});
         pops_total++;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (r_hs) begin
         chk(mem_q.size() != 0, "r_unexpected", 0, 1);
         if (mem_q.size() != 0) begin
            e = mem_q.pop_front();
            if (e.epoch == epoch && !redir) begin
               exp_q.push_back('{memdata(m_resp), m_resp, faulty(m_resp)});
               if (faulty(m_resp)) halted = 1;
               m_resp = m_resp + 32'd4;
            end
         end
      end
      if (ar_hs) begin
         mem_q.push_back('{araddr, ar_epoch, cyc + 1 + $urandom_range(lat_min, lat_max)});
         ar_hs_count++;
      end
      if (redir) begin
         epoch++;
         exp_q.delete();
         m_fetch = {redirect_pc[31:2], 2'b00};
         m_resp  = {redirect_pc[31:2], 2'b00};
         halted  = 0;
      end
      exp_launch = free && !redir && !halted && (credit < DEPTH);
      p_arvalid = arvalid; p_arready = arready; p_araddr = araddr;
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      rst = rst_req;
      drive();
      #1;
      if (!rst) eval();
      cyc++;
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      step();
      model_init();
      repeat (3) step();
      rst_req = 1'b0;
      step();
   endtask

   task automatic knobs(input int a, input int r, input int ir, input int rd, input int lmin, input int lmax);
      ar_pct = a; r_pct = r; ir_pct = ir; redir_pct = rd; lat_min = lmin; lat_max = lmax;
   endtask

   task automatic first_pop_after(input int n, input logic [31:0] exp_pc, input bit exp_fault, input string name);
      for (int i = 0; i < 60 && pop_log.size() <= n; i++) step();
      if (pop_log.size() > n) begin
         chk(pop_log[n].pc == exp_pc, name, pop_log[n].pc, exp_pc);
         chk(pop_log[n].fault == exp_fault, {name, "_fault"}, pop_log[n].fault, exp_fault);
      end else begin
         chk(1'b0, {name, "_timeout"}, pop_log.size(), n + 1);
      end
   endtask

   task automatic launch_at(input int n, input logic [31:0] exp_addr, input string name);
      for (int i = 0; i < 60 && launch_log.size() <= n; i++) step();
      if (launch_log.size() > n) chk(launch_log[n] == exp_addr, name, launch_log[n], exp_addr);
      else chk(1'b0, {name, "_timeout"}, launch_log.size(), n + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_p, n_l, p0, a0, idx;
      model_init();

      // streaming at full rate from reset
      knobs(100, 100, 100, 0, 0, 0);
      do_reset();
      repeat (10) step();
      p0 = pops_total;
      repeat (20) step();
      chk(pops_total - p0 == 20, "no_gaps", pops_total - p0, 20);
      chk(launch_log[0] == 32'h0, "first_ar", launch_log[0], 32'h0);
      chk(launch_log[2] == 32'h8, "third_ar", launch_log[2], 32'h8);
      chk(pop_log[0].pc == 32'h0 && pop_log[1].pc == 32'h4 && pop_log[2].pc == 32'h8,
          "pc_seq", {pop_log[1].pc, pop_log[2].pc}, {32'h4, 32'h8});
      chk(pop_log[1].data == memdata(32'h4), "data_4", pop_log[1].data, memdata(32'h4));

      // consumer stalled: credits stop fetch at DEPTH requests
      knobs(100, 100, 0, 0, 0, 0);
      do_reset();
      repeat (20) step();
      chk(ar_hs_count == 4, "stall_ar_count", ar_hs_count, 4);
      chk(inst_valid == 1'b1 && arvalid == 1'b0, "stall_state", {inst_valid, arvalid}, 2'b10);
      n_l = launch_log.size();
      ir_pct = 100;
      launch_at(n_l, 32'h10, "resume_ar");

      // redirect with responses in flight
      knobs(100, 100, 100, 0, 2, 2);
      do_reset();
      repeat (12) step();
      force_pc = 32'h103; force_redir = 1'b1;
      step();
      n_p = pop_log.size(); n_l = launch_log.size();
      first_pop_after(n_p, 32'h100, 1'b0, "redir_first_pc");
      launch_at(n_l, 32'h100, "redir_ar0");
      launch_at(n_l + 1, 32'h104, "redir_ar1");

      // redirect while an AR is held by arready=0
      knobs(100, 100, 100, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 10 && ar_hs_count < 1; i++) step();
      ar_pct = 0;
      repeat (3) step();
      chk(arvalid == 1'b1 && araddr == 32'h4, "held_ar", araddr, 32'h4);
      force_pc = 32'h200; force_redir = 1'b1;
      step();
      n_p = pop_log.size(); n_l = launch_log.size();
      repeat (3) step();
      chk(arvalid == 1'b1 && araddr == 32'h4, "held_ar_redir", araddr, 32'h4);
      ar_pct = 100;
      launch_at(n_l, 32'h200, "held_next_ar");
      first_pop_after(n_p, 32'h200, 1'b0, "held_first_pc");

      // access fault halts fetch until a redirect
      fault_addr = 32'h8;
      do_reset();
      repeat (15) step();
      a0 = ar_hs_count;
      repeat (15) step();
      chk(ar_hs_count == a0, "halt_no_ar", ar_hs_count, a0);
      idx = -1;
      foreach (pop_log[i]) if (idx < 0 && pop_log[i].pc == 32'h8) idx = i;
      chk(idx >= 0, "fault_entry_seen", idx, 0);
      if (idx >= 0) chk(pop_log[idx].fault == 1'b1, "fault_flag", pop_log[idx].fault, 1);
      fault_addr = 32'h1;
      force_pc = 32'h40; force_redir = 1'b1;
      step();
      n_p = pop_log.size();
      first_pop_after(n_p, 32'h40, 1'b0, "post_fault_pc");
      first_pop_after(n_p + 1, 32'h44, 1'b0, "post_fault_pc2");

      // redirect coinciding with a pop and an R handshake
      knobs(100, 100, 100, 0, 0, 0);
      do_reset();
      repeat (10) step();
      force_pc = 32'h300; force_redir = 1'b1;
      step();
      chk(ev_pop && ev_rhs, "redir_concurrent", {ev_pop, ev_rhs}, 2'b11);
      n_p = pop_log.size();
      @(posedge clk); #1;
      chk(inst_valid == 1'b0, "redir_flush", inst_valid, 0);
      first_pop_after(n_p, 32'h300, 1'b0, "redir_conc_pc");

      // randomized traffic with random redirects, faults and one mid-run reset
      rand_fault_en = 1'b1;
      do_reset();
      for (int b = 0; b < 15; b++) begin
         knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100), 3, 0,
               $urandom_range(0, 4));
         if (b == 7) do_reset();
         repeat (200) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
